// File: rtl/aes_pkg.sv
// Shared AES definitions used by the selector-error collector and its alert FSM.
package aes_pkg;

  localparam int AesSelErrCntW = 8;

  // Sparse 6-bit encodings, pairwise Hamming distance 4.
  typedef enum logic [5:0] {
    IDLE     = 6'b001110,
    REQ      = 6'b110100,
    WAIT_LOW = 6'b011001
  } aes_sel_err_state_e;

endpackage

// File: rtl/aes_sel_err_alert_fsm.sv
// Four-phase alert handshake FSM with the test-pending flag.
module aes_sel_err_alert_fsm
  import aes_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fatal_i,
  input  logic alert_test_i,
  input  logic alert_ack_i,
  output logic alert_req_o,
  output logic state_err_o
);

  logic [5:0] state_d, state_q;
  logic       test_pend_d, test_pend_q;
  logic       go_req;

  always_comb begin
    state_d     = state_q;
    state_err_o = 1'b0;
    go_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fatal_i || test_pend_q) begin
          state_d = REQ;
          go_req  = 1'b1;
        end
      end
      REQ:      if (alert_ack_i)  state_d = WAIT_LOW;
      WAIT_LOW: if (!alert_ack_i) state_d = IDLE;
      default: begin
        state_err_o = 1'b1;
        state_d     = REQ;
      end
    endcase
    // A pulse landing on the launching edge is served by that same handshake.
    test_pend_d = go_req ? 1'b0 : (test_pend_q | alert_test_i);
  end

  assign alert_req_o = (state_q == REQ);

  caliptra_prim_sec_anchor_flop #(
    .Width      (6),
    .ResetValue (IDLE)
  ) u_state_regs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (state_d),
    .q_o    (state_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) test_pend_q <= 1'b0;
    else         test_pend_q <= test_pend_d;
  end

endmodule

// File: rtl/caliptra_prim_sec_anchor_flop.sv
// Register whose contents synthesis must keep bit-for-bit (no re-encoding).
module caliptra_prim_sec_anchor_flop #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= ResetValue;
    else         q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/aes_sel_err_collect.sv
// Sticky collector for sparse mux-selector checker errors with alert request.
// Optional saturating error-cycle counter enabled by `define AES_SEL_ERR_CNT_EN.
module aes_sel_err_collect
  import aes_pkg::*;
#(
  parameter int NumChk = 8,
  parameter int IdxW   = (NumChk > 1) ? $clog2(NumChk) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumChk-1:0]        err_i,
  input  logic                     alert_test_i,
  input  logic                     alert_ack_i,
  output logic                     alert_req_o,
  output logic                     err_fatal_o,
  output logic [NumChk-1:0]        err_vec_o,
  output logic [IdxW-1:0]          err_idx_o,
  output logic [AesSelErrCntW-1:0] err_cnt_o
);

  logic              any_err, state_err;
  logic [NumChk-1:0] err_vec_d, err_vec_q;
  logic              err_fatal_d, err_fatal_q;
  logic [IdxW-1:0]   first_idx, err_idx_d, err_idx_q;

  assign any_err = |err_i;

  always_comb begin
    first_idx = '0;
    for (int k = NumChk - 1; k >= 0; k--) begin
      if (err_i[k]) first_idx = IdxW'(k);
    end
  end

  always_comb begin
    err_vec_d   = err_vec_q | err_i;
    err_fatal_d = err_fatal_q | any_err | state_err;
    // Only the very first checker-error cycle records an index.
    err_idx_d   = (any_err && !err_fatal_q) ? first_idx : err_idx_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_vec_q   <= '0;
      err_fatal_q <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      err_vec_q   <= err_vec_d;
      err_fatal_q <= err_fatal_d;
      err_idx_q   <= err_idx_d;
    end
  end

`ifdef AES_SEL_ERR_CNT_EN
  logic [AesSelErrCntW-1:0] err_cnt_d, err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (any_err && (err_cnt_q != {AesSelErrCntW{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  aes_sel_err_alert_fsm u_alert_fsm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fatal_i      (err_fatal_q),
    .alert_test_i (alert_test_i),
    .alert_ack_i  (alert_ack_i),
    .alert_req_o  (alert_req_o),
    .state_err_o  (state_err)
  );

  assign err_fatal_o = err_fatal_q;
  assign err_vec_o   = err_vec_q;
  assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_aes_sel_err_collect.sv
// Directed + randomized self-checking bench for aes_sel_err_collect.
module tb_aes_sel_err_collect;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] err_i;
  logic       alert_test_i;
  logic       alert_ack_i;
  logic       alert_req_o;
  logic       err_fatal_o;
  logic [7:0] err_vec_o;
  logic [2:0] err_idx_o;
  logic [7:0] err_cnt_o;

  int checks = 0;
  int errors = 0;
  bit ack_en = 1'b0;
  int rises  = 0;

  // Reference model state
  logic [7:0] m_vec;
  logic       m_fatal;
  int         m_idx;
  int         m_cnt;

  aes_sel_err_collect dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .err_i        (err_i),
    .alert_test_i (alert_test_i),
    .alert_ack_i  (alert_ack_i),
    .alert_req_o  (alert_req_o),
    .err_fatal_o  (err_fatal_o),
    .err_vec_o    (err_vec_o),
    .err_idx_o    (err_idx_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Alert sender: acknowledge two cycles after a request, drop once req falls.
  initial begin
    int dly;
    dly = 0;
    alert_ack_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      if (!ack_en) begin
        alert_ack_i = 1'b0;
        dly = 0;
      end else if (alert_req_o && !alert_ack_i) begin
        dly++;
        if (dly >= 2) alert_ack_i = 1'b1;
      end else if (!alert_req_o && alert_ack_i) begin
        alert_ack_i = 1'b0;
        dly = 0;
      end
    end
  end

  // Count rising edges of the request.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(posedge clk_i);
      #3;
      if (alert_req_o && !prev) rises++;
      prev = alert_req_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    ack_en = 1'b0;
    err_i = '0;
    alert_test_i = 1'b0;
    rst_ni = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    m_vec = '0; m_fatal = 1'b0; m_idx = 0; m_cnt = 0;
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] cnt_exp(input int c);
`ifdef AES_SEL_ERR_CNT_EN
    return 8'(c);
`else
    return 8'(c * 0);
`endif
  endfunction

  initial begin
    logic [7:0] r;
    err_i = '0; alert_test_i = 1'b0; rst_ni = 1'b0;
    do_reset();

    // Idle after reset: everything stays quiet.
    rises = 0;
    repeat (20) begin
      tick();
      chk("idle_outs", {7'd0, alert_req_o, err_fatal_o, err_vec_o, 5'd0, err_idx_o, err_cnt_o}, 32'd0);
    end
    chk("idle_no_req", rises, 0);

    // First error 0x28: index 3, request one cycle later.
    err_i = 8'h28;
    tick();
    err_i = 8'h00;
    chk("e1_vec", err_vec_o, 8'h28);
    chk("e1_idx", err_idx_o, 3);
    chk("e1_fatal", err_fatal_o, 1);
    chk("e1_req_early", alert_req_o, 0);
    tick();
    chk("e1_req", alert_req_o, 1);
    err_i = 8'h01;
    tick();
    err_i = 8'h00;
    chk("e2_vec", err_vec_o, 8'h29);
    chk("e2_idx_frozen", err_idx_o, 3);
    rises = 0;
    ack_en = 1'b1;
    repeat (24) tick();
    chk("fatal_repeat", (rises >= 3), 1);
    chk("fatal_sticky", err_fatal_o, 1);

    // Single test pulse: exactly one handshake.
    do_reset();
    ack_en = 1'b1;
    rises = 0;
    alert_test_i = 1'b1; tick(); alert_test_i = 1'b0;
    tick();
    chk("test_req_lat", alert_req_o, 1);
    repeat (20) tick();
    chk("test_one_hs", rises, 1);
    chk("test_back_idle", alert_req_o, 0);
    chk("test_no_fatal", err_fatal_o, 0);

    // Back-to-back pulses merge into one handshake.
    rises = 0;
    alert_test_i = 1'b1; tick(); tick(); alert_test_i = 1'b0;
    repeat (20) tick();
    chk("test_merge", rises, 1);

    // Pulse during REQ earns exactly one extra handshake.
    rises = 0;
    alert_test_i = 1'b1; tick(); alert_test_i = 1'b0;
    tick(); tick();
    alert_test_i = 1'b1; tick(); alert_test_i = 1'b0;
    repeat (24) tick();
    chk("test_in_req", rises, 2);

    // Asynchronous reset in the middle of REQ.
    do_reset();
    err_i = 8'h44; tick(); err_i = 8'h00;
    tick();
    chk("mid_req_pre", alert_req_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_req_rst", {7'd0, alert_req_o, err_fatal_o, err_vec_o, 5'd0, err_idx_o, err_cnt_o}, 32'd0);
    tick(); tick();
    rst_ni = 1'b1;

    // Invalid FSM encoding: fatal without index or vector.
    do_reset();
    tick();
    force dut.u_alert_fsm.state_d = 6'b111111;
    tick();
    release dut.u_alert_fsm.state_d;
    chk("inv_fatal_pre", err_fatal_o, 0);
    tick();
    chk("inv_fatal", err_fatal_o, 1);
    chk("inv_req", alert_req_o, 1);
    chk("inv_idx", err_idx_o, 0);
    chk("inv_vec", err_vec_o, 0);
    tick();
    chk("inv_req_hold", alert_req_o, 1);

    // Randomized error traffic against the model.
    do_reset();
    ack_en = 1'b1;
    repeat (80) begin
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      err_i = r;
      if (r != 0) begin
        if (!m_fatal) m_idx = lowest(r);
        m_fatal = 1'b1;
        m_vec |= r;
        if (m_cnt < 255) m_cnt++;
      end
      tick();
      chk("rnd_vec", err_vec_o, m_vec);
      chk("rnd_idx", err_idx_o, m_idx);
      chk("rnd_fatal", err_fatal_o, m_fatal);
      chk("rnd_cnt", err_cnt_o, cnt_exp(m_cnt));
    end

    // Long error burst: counter saturation.
    do_reset();
    repeat (300) begin
      err_i = 8'($urandom_range(1, 255));
      if (m_cnt < 255) m_cnt++;
      tick();
    end
    err_i = 8'h00;
    chk("cnt_sat_model", m_cnt, 255);
    chk("cnt_sat", err_cnt_o, cnt_exp(255));
    tick();
    chk("cnt_hold", err_cnt_o, cnt_exp(255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
